// File: rtl/tdc_code_averager.sv
// tdc_code_averager: thermometer-to-code encoder with batch mean/min/max and valid/ready result
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            pulse: clear stats and begin a batch (ignored in DONE)
//   samp_valid/therm snapshot input, bit0 = first tap
//   busy             high while accumulating or draining
//   res_valid/ready  result handshake; res_mean/min/max are the batch statistics
//   drop             sticky flag for snapshots arriving outside accumulation
// Optional feature: define TDC_BUBBLE_FILTER_EN to majority-filter each snapshot before encoding.
module tdc_code_averager #(
    parameter int TAPS     = 64,
    parameter int LOG2_AVG = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            samp_valid,
    input  logic [TAPS-1:0]                 therm,
    output logic                            busy,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [$clog2(TAPS+1)-1:0]       res_mean,
    output logic [$clog2(TAPS+1)-1:0]       res_min,
    output logic [$clog2(TAPS+1)-1:0]       res_max,
    output logic                            drop
);
    localparam int CODE_W = $clog2(TAPS + 1);
    localparam int ACC_W  = CODE_W + LOG2_AVG;
    localparam int CNT_W  = LOG2_AVG + 1;
    localparam int N      = 1 << LOG2_AVG;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [TAPS-1:0]   filt, s1_t;
    logic              s1_v, s2_v;
    logic [CODE_W-1:0] code, s2_code, mn, mx;
    logic [ACC_W-1:0]  acc, mean_full;
    logic [CNT_W-1:0]  cnt;
    logic              start_eff, accept, last;

`ifdef TDC_BUBBLE_FILTER_EN
    logic [TAPS+1:0] ext;
    assign ext = {1'b0, therm, 1'b1};
    for (genvar i = 0; i < TAPS; i++) begin : g_maj
        assign filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
`else
    assign filt = therm;
`endif

    // Count of leading ones from bit0: the lowest zero position wins.
    always_comb begin
        code = CODE_W'(TAPS);
        for (int i = TAPS - 1; i >= 0; i--)
            if (!s1_t[i]) code = CODE_W'(i);
    end

    assign start_eff = start && state != DONE;
    assign accept    = state == ACC && samp_valid && !start;
    assign last      = cnt == CNT_W'(N - 1);
    assign busy      = state == ACC || state == DRAIN;
    assign res_valid = state == DONE;
    assign mean_full = acc >> LOG2_AVG;

    always_comb begin
        state_n = state;
        if (start_eff)
            state_n = ACC;
        else if (accept && last)
            state_n = DRAIN;
        else if (state == DRAIN && !s1_v && !s2_v)
            state_n = DONE;
        else if (state == DONE && res_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_t     <= '0;
            s2_code  <= '0;
            acc      <= '0;
            cnt      <= '0;
            mn       <= CODE_W'(TAPS);
            mx       <= '0;
            drop     <= 1'b0;
            res_mean <= '0;
            res_min  <= CODE_W'(TAPS);
            res_max  <= '0;
        end else begin
            state <= state_n;
            s1_v  <= accept;
            s2_v  <= s1_v && !start_eff;
            if (accept)
                s1_t <= filt;
            if (s1_v)
                s2_code <= code;
            if (start_eff) begin
                acc <= '0;
                mn  <= CODE_W'(TAPS);
                mx  <= '0;
            end else if (s2_v) begin
                acc <= acc + ACC_W'(s2_code);
                mn  <= s2_code < mn ? s2_code : mn;
                mx  <= s2_code > mx ? s2_code : mx;
            end
            cnt  <= start_eff ? '0 : accept ? cnt + 1'b1 : cnt;
            drop <= start_eff ? 1'b0 : (samp_valid && state != ACC) ? 1'b1 : drop;
            if (state == DRAIN && state_n == DONE) begin
                res_mean <= mean_full[CODE_W-1:0];
                res_min  <= mn;
                res_max  <= mx;
            end
        end
    end
endmodule
